mult_unit: RTL and testbench



---
 rtl/mult_unit_if.sv | 15 +
 rtl/mult_unit.sv | 101 ++++++++++
 tb/tb_mult_unit.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mult_unit_if.sv
// Decode-to-multiplier handshake: request, operands, and the completion/result path.
interface mult_unit_if #(parameter int WIDTH = 64);
  logic             mult_start;
  logic [1:0]       mult_mode;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             busy;
  logic             multiplier_done;
  logic [WIDTH-1:0] result;

  modport master (output mult_start, mult_mode, operand_a, operand_b,
                  input  busy, multiplier_done, result);
  modport slave  (input  mult_start, mult_mode, operand_a, operand_b,
                  output busy, multiplier_done, result);
endinterface

// File: rtl/mult_unit.sv
// Iterative shift-add multiplier: one multiplier bit per clock, then a sign
// fix-up/half-select cycle that pulses multiplier_done to release decode.
module mult_unit #(parameter int WIDTH = 64) (
  input  logic      clk,
  input  logic      reset,
  mult_unit_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam int CW = $clog2(WIDTH) + 1;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [1:0]         mode_q, mode_d;
  logic               neg_q, neg_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   abs_a, abs_b, addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;

  // Magnitudes for SMULH; the most negative value maps onto itself, which is
  // exactly 2^(WIDTH-1) read as unsigned.
  assign abs_a  = bus.operand_a[WIDTH-1] ? -bus.operand_a : bus.operand_a;
  assign abs_b  = bus.operand_b[WIDTH-1] ? -bus.operand_b : bus.operand_b;

  // Shift-right accumulator: the multiplier sits in the low half and is
  // consumed LSB first while partial sums enter from the top.
  assign addend = acc_q[0] ? mcand_q : '0;
  assign sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  assign prod   = neg_q ? -acc_q : acc_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    res_d   = res_q;
    mode_d  = mode_q;
    neg_d   = neg_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (bus.mult_start) begin
        state_d = RUN;
        mode_d  = bus.mult_mode;
        cnt_d   = '0;
        if (bus.mult_mode == 2'b01) begin
          mcand_d = abs_a;
          acc_d   = {{WIDTH{1'b0}}, abs_b};
          neg_d   = bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1];
        end else begin
          mcand_d = bus.operand_a;
          acc_d   = {{WIDTH{1'b0}}, bus.operand_b};
          neg_d   = 1'b0;
        end
      end
      RUN: begin
        acc_d = {sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        // Modes 01/10 take the high half; 00 and reserved 11 take the low half.
        res_d   = (^mode_q) ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      res_q   <= '0;
      mode_q  <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      res_q   <= res_d;
      mode_q  <= mode_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy            = (state_q != IDLE);
  assign bus.multiplier_done = done_q;
  assign bus.result          = res_q;
endmodule

// File: tb/tb_mult_unit.sv
// Randomized and directed checks of mult_unit against a plain-arithmetic product model.
module tb_mult_unit;
  logic clk, reset;
  int   total = 0, bad = 0;
  logic [63:0] last_res;

  mult_unit_if #(.WIDTH(64)) bus ();
  mult_unit #(.WIDTH(64)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [1:0] m, input logic [63:0] a,
                                          input logic [63:0] b);
    logic [127:0] p;
    case (m)
      2'b01: begin
        p = {{64{a[63]}}, a} * {{64{b[63]}}, b};
        return p[127:64];
      end
      2'b10: begin
        p = {64'b0, a} * {64'b0, b};
        return p[127:64];
      end
      default: begin
        p = {64'b0, a} * {64'b0, b};
        return p[63:0];
      end
    endcase
  endfunction

  task automatic wait_done(output int n);
    n = 0;
    while (bus.multiplier_done !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] m, input logic [63:0] a,
                        input logic [63:0] b);
    int n;
    logic [63:0] exp;
    exp = ref_mul(m, a, b);
    @(negedge clk);
    bus.mult_mode = m; bus.operand_a = a; bus.operand_b = b; bus.mult_start = 1'b1;
    @(posedge clk); #1;
    bus.mult_start = 1'b0;
    bus.operand_a = $urandom(); bus.operand_b = $urandom(); bus.mult_mode = 2'($urandom());
    chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
    wait_done(n);
    chk({tag, "_lat"}, 64'(n), 64'd65);
    chk({tag, "_res"}, bus.result, exp);
    chk({tag, "_busy_done"}, 64'(bus.busy), 64'd0);
    last_res = bus.result;
    @(posedge clk); #1;
    chk({tag, "_one_pulse"}, 64'(bus.multiplier_done), 64'd0);
    chk({tag, "_hold"}, bus.result, exp);
  endtask

  initial begin
    int n, pulses, first;
    logic [63:0] a, b;
    bus.mult_start = 1'b0; bus.mult_mode = 2'b00; bus.operand_a = '0; bus.operand_b = '0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.multiplier_done), 64'd0);
    chk("rst_res",  bus.result, 64'd0);
    @(negedge clk) reset = 1'b1;

    // Directed cases with known answers
    run_op("t1", 2'b00, 64'd7, 64'd6);
    chk("t1_const", last_res, 64'd42);
    run_op("t2a", 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    chk("t2a_const", last_res, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("t2b", 2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    chk("t2b_const", last_res, 64'h4000_0000_0000_0000);
    run_op("t3a", 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t3a_const", last_res, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("t3b", 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t3b_const", last_res, 64'd1);
    run_op("t3c", 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t3c_const", last_res, 64'd1);

    // Request while busy is ignored; operand changes after acceptance are ignored
    @(negedge clk);
    bus.mult_mode = 2'b00; bus.operand_a = 64'd3; bus.operand_b = 64'd5; bus.mult_start = 1'b1;
    @(posedge clk); #1;
    bus.mult_start = 1'b0;
    pulses = 0; first = 0;
    for (int i = 1; i <= 140; i++) begin
      @(posedge clk); #1;
      if (bus.multiplier_done === 1'b1) begin
        pulses++;
        if (first == 0) begin
          first = i;
          chk("t4_res", bus.result, 64'd15);
        end
      end
      if (i == 19) begin
        bus.mult_start = 1'b1; bus.operand_a = 64'd9; bus.operand_b = 64'd9;
      end
      if (i == 20) begin
        bus.mult_start = 1'b0; bus.operand_a = 64'hDEAD_BEEF;
        chk("t4_busy_mid", 64'(bus.busy), 64'd1);
        chk("t4_res_mid", bus.result, last_res);
      end
    end
    chk("t4_lat", 64'(first), 64'd65);
    chk("t4_pulses", 64'(pulses), 64'd1);

    // Held request: back-to-back acceptance straight out of the done cycle
    @(negedge clk);
    bus.mult_mode = 2'b00; bus.operand_a = 64'd3; bus.operand_b = 64'd5; bus.mult_start = 1'b1;
    @(posedge clk); #1;
    wait_done(n);
    chk("t5_lat1", 64'(n), 64'd65);
    chk("t5_res1", bus.result, 64'd15);
    bus.operand_a = 64'd2; bus.operand_b = 64'd8;
    @(posedge clk); #1;
    bus.mult_start = 1'b0;
    chk("t5_busy2", 64'(bus.busy), 64'd1);
    wait_done(n);
    chk("t5_lat2", 64'(n), 64'd65);
    chk("t5_res2", bus.result, 64'd16);

    // Asynchronous reset mid-operation
    run_op("t6pre", 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    bus.mult_mode = 2'b10; bus.operand_a = 64'h1234_5678_9ABC_DEF0; bus.operand_b = 64'hFFFF_0000_FFFF_0000;
    bus.mult_start = 1'b1;
    @(posedge clk); #1;
    bus.mult_start = 1'b0;
    repeat (30) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6_busy", 64'(bus.busy), 64'd0);
    chk("t6_done", 64'(bus.multiplier_done), 64'd0);
    chk("t6_res",  bus.result, 64'd0);
    @(negedge clk) reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (bus.multiplier_done === 1'b1 || bus.busy === 1'b1) pulses++;
    end
    chk("t6_quiet", 64'(pulses), 64'd0);

    // Randomized operations against the model
    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 3))
        0: a = 64'h8000_0000_0000_0000;
        1: a = 64'hFFFF_FFFF_FFFF_FFFF;
        default: a = {$urandom(), $urandom()};
      endcase
      b = ($urandom_range(0, 4) == 0) ? 64'h8000_0000_0000_0000 : {$urandom(), $urandom()};
      run_op($sformatf("rnd%0d", k), 2'($urandom_range(0, 3)), a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
